dmem_arbiter: RTL and testbench

- Shares the processor's single-port, synchronous-read data memory between two requesters:
  - the core, driven by the control unit's data-address and write-enable outputs;
  - a host/debug port that preloads and inspects data memory, e.g. D[1B], D[2A] before a run and D[6A] after HALT.
- Fixed priority to the core, with a starvation counter that guarantees the host progress.
- Read data returns one cycle after grant and is steered to the requester that issued the read.

---
 rtl/dmem_arb_pkg.sv | 15 +
 rtl/dmem_arbiter_if.sv | 53 +++++
 rtl/dmem_arb_starve.sv | 34 +++
 rtl/dmem_arbiter.sv | 89 ++++++++
 tb/tb_dmem_arbiter.sv | 211 +++++++++++++++++++++
 5 files changed

// File: rtl/dmem_arb_pkg.sv
// Shared types and defaults for the data-memory arbiter.
package dmem_arb_pkg;

  typedef enum logic [1:0] {OWN_NONE, OWN_CORE, OWN_HOST} owner_t;

  localparam int DEF_ADDR_W     = 8;
  localparam int DEF_DATA_W     = 16;
  localparam int DEF_STARVE_MAX = 4;

  // Bits needed to hold 0..max_cnt inclusive.
  function automatic int cnt_w(input int max_cnt);
    return $clog2(max_cnt + 1);
  endfunction

endpackage

// File: rtl/dmem_arbiter_if.sv
// Core, host and memory-side signals of the data-memory arbiter.
interface dmem_arbiter_if
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
);
  logic              core_req;
  logic              core_we;
  logic [ADDR_W-1:0] core_addr;
  logic [DATA_W-1:0] core_wdata;
  logic              core_gnt;
  logic              core_rvalid;
  logic [DATA_W-1:0] core_rdata;

  logic              host_req;
  logic              host_we;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_wdata;
  logic              host_gnt;
  logic              host_rvalid;
  logic [DATA_W-1:0] host_rdata;

  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  logic              host_pri;

  // Arbiter side.
  modport slave (
    input  core_req, core_we, core_addr, core_wdata,
    output core_gnt, core_rvalid, core_rdata,
    input  host_req, host_we, host_addr, host_wdata,
    output host_gnt, host_rvalid, host_rdata,
    output mem_addr, mem_we, mem_wdata,
    input  mem_rdata,
    output host_pri
  );

  // Requesters plus memory side.
  modport master (
    output core_req, core_we, core_addr, core_wdata,
    input  core_gnt, core_rvalid, core_rdata,
    output host_req, host_we, host_addr, host_wdata,
    input  host_gnt, host_rvalid, host_rdata,
    input  mem_addr, mem_we, mem_wdata,
    output mem_rdata,
    input  host_pri
  );

endinterface

// File: rtl/dmem_arb_starve.sv
// Host starvation tracker: counts consecutive refused host cycles and
// hands the host priority once the count has saturated.
module dmem_arb_starve
  import dmem_arb_pkg::*;
#(
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input  logic Clk,
  input  logic Reset,
  input  logic host_req,
  input  logic host_gnt,
  output logic host_pri
);

  localparam int            CW      = cnt_w(STARVE_MAX);
  localparam logic [CW-1:0] CNT_MAX = CW'(STARVE_MAX);

  logic [CW-1:0] starve_cnt;

  // Saturating count of consecutive refusals; any service or a dropped request restarts it.
  always_ff @(posedge Clk) begin
    if (Reset)                       starve_cnt <= '0;
    else if (!host_req || host_gnt)  starve_cnt <= '0;
    else if (starve_cnt != CNT_MAX)  starve_cnt <= starve_cnt + 1'b1;
  end

  // Priority rises one cycle after saturation and falls after the host is served.
  always_ff @(posedge Clk) begin
    if (Reset)                       host_pri <= 1'b0;
    else if (!host_req || host_gnt)  host_pri <= 1'b0;
    else if (starve_cnt == CNT_MAX)  host_pri <= 1'b1;
  end

endmodule

// File: rtl/dmem_arbiter.sv
// Two-requester arbiter for the single-port synchronous-read data memory.
// Core has fixed priority unless the starvation tracker promotes the host.
module dmem_arbiter
  import dmem_arb_pkg::*;
#(
  parameter int ADDR_W     = DEF_ADDR_W,
  parameter int DATA_W     = DEF_DATA_W,
  parameter int STARVE_MAX = DEF_STARVE_MAX
) (
  input logic           Clk,
  input logic           Reset,
  dmem_arbiter_if.slave bus
);

  logic              core_win, host_win, pri;
  logic              sel_we;
  logic [ADDR_W-1:0] sel_addr, last_addr;
  logic [DATA_W-1:0] sel_wdata, last_wdata;
  owner_t            rd_owner;

  dmem_arb_starve #(.STARVE_MAX(STARVE_MAX)) u_starve (
    .Clk      (Clk),
    .Reset    (Reset),
    .host_req (bus.host_req),
    .host_gnt (host_win),
    .host_pri (pri)
  );

  // Single winner per cycle; host wins on priority or when the core is idle.
  always_comb begin
    host_win = 1'b0;
    core_win = 1'b0;
    if (!Reset) begin
      host_win = bus.host_req && (pri || !bus.core_req);
      core_win = bus.core_req && !host_win;
    end
  end

  // Steer the winner onto the memory bus; hold the last address/data when idle.
  always_comb begin
    sel_addr  = last_addr;
    sel_wdata = last_wdata;
    sel_we    = 1'b0;
    if (core_win) begin
      sel_addr  = bus.core_addr;
      sel_wdata = bus.core_wdata;
      sel_we    = bus.core_we;
    end else if (host_win) begin
      sel_addr  = bus.host_addr;
      sel_wdata = bus.host_wdata;
      sel_we    = bus.host_we;
    end
  end

  // Remember what was last driven so an idle bus stays put.
  always_ff @(posedge Clk) begin
    if (Reset) begin
      last_addr  <= '0;
      last_wdata <= '0;
    end else if (core_win || host_win) begin
      last_addr  <= sel_addr;
      last_wdata <= sel_wdata;
    end
  end

  // Tag which requester owns the read data arriving next cycle.
  always_ff @(posedge Clk) begin
    if (Reset)                         rd_owner <= OWN_NONE;
    else if (core_win && !bus.core_we) rd_owner <= OWN_CORE;
    else if (host_win && !bus.host_we) rd_owner <= OWN_HOST;
    else                               rd_owner <= OWN_NONE;
  end

  // Return read data to its owner; Reset squashes a read landing in its cycle.
  always_comb begin
    bus.core_rvalid = !Reset && (rd_owner == OWN_CORE);
    bus.host_rvalid = !Reset && (rd_owner == OWN_HOST);
    bus.core_rdata  = bus.core_rvalid ? bus.mem_rdata : '0;
    bus.host_rdata  = bus.host_rvalid ? bus.mem_rdata : '0;
  end

  assign bus.core_gnt  = core_win;
  assign bus.host_gnt  = host_win;
  assign bus.host_pri  = pri;
  assign bus.mem_we    = sel_we;
  assign bus.mem_addr  = Reset ? '0 : sel_addr;
  assign bus.mem_wdata = Reset ? '0 : sel_wdata;

endmodule

// File: tb/tb_dmem_arbiter.sv
// Scoreboard bench for dmem_arbiter: directed scenarios followed by random traffic.
module tb_dmem_arbiter;

  localparam int AW   = 8;
  localparam int DW   = 16;
  localparam int SMAX = 4;

  typedef struct {
    int            due;
    logic [DW-1:0] data;
  } rd_t;

  logic Clk = 1'b0;
  logic Reset = 1'b1;

  dmem_arbiter_if #(.ADDR_W(AW), .DATA_W(DW)) bus();

  dmem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
    .Clk   (Clk),
    .Reset (Reset),
    .bus   (bus)
  );

  always #5 Clk = ~Clk;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;

  rd_t cq[$];
  rd_t hq[$];

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return {8'hA5, a};
  endfunction

  // Synchronous-read memory; unwritten words read as init_val.
  logic [DW-1:0] tbmem [256];
  bit            tbw   [256];
  always @(posedge Clk) begin
    if (bus.mem_we) begin
      tbmem[bus.mem_addr] <= bus.mem_wdata;
      tbw[bus.mem_addr]   <= 1'b1;
    end
    bus.mem_rdata <= tbw[bus.mem_addr] ? tbmem[bus.mem_addr] : init_val(bus.mem_addr);
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s cyc=%0d got=%0h want=%0h", name, cyc, act, exp);
    end
  endtask

  // Reference model state
  logic [DW-1:0] ref_mem [256];
  int            streak;
  logic [AW-1:0] m_last_addr;
  logic [DW-1:0] m_last_wd;

  // Requester stimulus
  logic          rst_v;
  logic          c_req, c_we, h_req, h_we;
  logic [AW-1:0] c_addr, h_addr;
  logic [DW-1:0] c_wd, h_wd;

  // One clock: drive at negedge, predict and check combinational outputs at +1.
  task automatic step();
    logic          eg_c, eg_h, epri, ewe;
    logic [AW-1:0] ea;
    logic [DW-1:0] ed;
    rd_t           it;
    @(negedge Clk);
    cyc++;
    Reset          = rst_v;
    bus.core_req   = c_req;  bus.core_we = c_we;  bus.core_addr = c_addr;  bus.core_wdata = c_wd;
    bus.host_req   = h_req;  bus.host_we = h_we;  bus.host_addr = h_addr;  bus.host_wdata = h_wd;
    #1;
    if (rst_v) begin
      eg_c = 1'b0; eg_h = 1'b0; ewe = 1'b0; ea = '0; ed = '0;
      cq.delete(); hq.delete();
      streak = 0; m_last_addr = '0; m_last_wd = '0;
    end else begin
      // Host is promoted after more than SMAX consecutive refusals.
      epri = (streak > SMAX);
      chk("host_pri", bus.host_pri, epri);
      eg_h = h_req && (epri || !c_req);
      eg_c = c_req && !eg_h;
      ewe = 1'b0; ea = m_last_addr; ed = m_last_wd;
      if (eg_c || eg_h) begin
        ea  = eg_c ? c_addr : h_addr;
        ed  = eg_c ? c_wd   : h_wd;
        ewe = eg_c ? c_we   : h_we;
        m_last_addr = ea; m_last_wd = ed;
        if (ewe) ref_mem[ea] = ed;
        else begin
          it.due = cyc + 1; it.data = ref_mem[ea];
          if (eg_c) cq.push_back(it); else hq.push_back(it);
        end
      end
      streak = (h_req && !eg_h) ? streak + 1 : 0;
    end
    chk("core_gnt", bus.core_gnt, eg_c);
    chk("host_gnt", bus.host_gnt, eg_h);
    chk("mem_we", bus.mem_we, ewe);
    chk("mem_addr", bus.mem_addr, ea);
    chk("mem_wdata", bus.mem_wdata, ed);
    if (eg_c) c_req = 1'b0;
    if (eg_h) h_req = 1'b0;
  endtask

  // Monitor: every cycle, match rvalid/rdata against the queued expectations.
  initial begin
    bit ec, eh;
    forever begin
      @(negedge Clk);
      #2;
      ec = (cq.size() > 0) && (cq[0].due == cyc);
      eh = (hq.size() > 0) && (hq[0].due == cyc);
      chk("core_rvalid", bus.core_rvalid, ec);
      chk("host_rvalid", bus.host_rvalid, eh);
      if (ec) begin
        chk("core_rdata", bus.core_rdata, cq[0].data);
        chk("host_rdata_idle", bus.host_rdata, 0);
        void'(cq.pop_front());
      end
      if (eh) begin
        chk("host_rdata", bus.host_rdata, hq[0].data);
        chk("core_rdata_idle", bus.core_rdata, 0);
        void'(hq.pop_front());
      end
    end
  end

  function automatic logic [AW-1:0] rand_addr();
    return ($urandom_range(0, 7) == 0) ? AW'($urandom) : AW'($urandom_range(0, 15));
  endfunction

  initial begin
    int first_h;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_val(AW'(i));
    streak = 0; m_last_addr = '0; m_last_wd = '0;
    c_we = 0; c_addr = '0; c_wd = '0; h_we = 0; h_addr = '0; h_wd = '0;

    // Reset with both requesting: nothing granted; core wins the first free cycle.
    rst_v = 1; c_req = 1; c_addr = 8'h10; h_req = 1; h_addr = 8'h11;
    repeat (2) step();
    rst_v = 0;
    step();
    chk("first_gnt_core", {bus.core_gnt, bus.host_gnt}, 2'b10);
    step();

    // Host write then read-back of D[1B].
    h_req = 1; h_we = 1; h_addr = 8'h1B; h_wd = 16'h21BA;
    step();
    chk("host_wr_gnt", {bus.host_gnt, bus.mem_we, bus.mem_addr}, {2'b11, 8'h1B});
    h_req = 1; h_we = 0;
    step();
    step();
    chk("host_rd_1b", {bus.host_rvalid, bus.host_rdata, bus.core_rvalid}, {1'b1, 16'h21BA, 1'b0});

    // Core reads every cycle while the host waits: host served on cycle 6.
    rst_v = 1; step(); rst_v = 0;
    first_h = 0;
    for (int i = 1; i <= 10 && first_h == 0; i++) begin
      c_req = 1; c_we = 0; c_addr = AW'(i + 32);
      h_req = 1; h_we = 0; h_addr = 8'h40;
      step();
      if (bus.host_gnt === 1'b1) first_h = i;
    end
    chk("starve_host_gnt_cycle", first_h, 6);
    c_req = 1; c_addr = 8'h07;
    step();
    chk("pri_cleared", bus.host_pri, 0);
    chk("core_after_pri", bus.core_gnt, 1);

    // Back-to-back core read of 2A then host read of 3C.
    c_req = 1; c_we = 0; c_addr = 8'h2A; h_req = 1; h_we = 0; h_addr = 8'h3C;
    repeat (4) step();

    // Reset right after a granted read: the read is dropped.
    c_req = 1; c_we = 0; c_addr = 8'h05;
    step();
    rst_v = 1; step();
    chk("rst_drop_rvalid", bus.core_rvalid, 0);
    rst_v = 0; step();
    chk("post_rst_rvalid", bus.core_rvalid, 0);

    // Random traffic with occasional cancels and resets.
    for (int n = 0; n < 3000; n++) begin
      rst_v = ($urandom_range(0, 199) == 0);
      if (!c_req) begin
        c_req = ($urandom_range(0, 9) < 7); c_we = ($urandom_range(0, 2) == 0);
        c_addr = rand_addr(); c_wd = DW'($urandom);
      end else if ($urandom_range(0, 15) == 0) c_req = 0;
      if (!h_req) begin
        h_req = ($urandom_range(0, 9) < 5); h_we = ($urandom_range(0, 1) == 0);
        h_addr = rand_addr(); h_wd = DW'($urandom);
      end else if ($urandom_range(0, 15) == 0) h_req = 0;
      step();
    end

    rst_v = 0; c_req = 0; h_req = 0;
    repeat (3) step();
    chk("sb_drain", cq.size() + hq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
